// File: rtl/apb_master_port_if.sv
// rtl/apb_master_port_if.sv - request/response channel and APB bus bundle for apb_master_port
//
// Purpose: groups the requester-side valid/ready channels and the APB
// initiator signals into one bundle so the port and its environment share
// a single connection point.
//
// Modports:
//   master - the APB initiator (apb_master_port): drives req_ready_o, rsp_*,
//            PADDR/PWDATA/PWRITE/PSEL/PENABLE; samples req_*, rsp_ready_i,
//            PRDATA/PREADY/PSLVERR.
//   slave  - the environment: the requester, the response consumer and the
//            APB slave, with every direction reversed.
//
// APB_ADDR_WIDTH must match the value given to apb_master_port.

interface apb_master_port_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    // Request channel
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [31:0]               req_wdata_i;
    logic                      req_write_i;

    // Response channel
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [31:0]               rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;

    // APB bus
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i,
        output req_ready_o,
        input  req_addr_i,
        input  req_wdata_i,
        input  req_write_i,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_rdata_o,
        output rsp_err_o,
        output rsp_timeout_o,
        output PADDR,
        output PWDATA,
        output PWRITE,
        output PSEL,
        output PENABLE,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR
    );

    modport slave (
        output req_valid_i,
        input  req_ready_o,
        output req_addr_i,
        output req_wdata_i,
        output req_write_i,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_rdata_o,
        input  rsp_err_o,
        input  rsp_timeout_o,
        input  PADDR,
        input  PWDATA,
        input  PWRITE,
        input  PSEL,
        input  PENABLE,
        output PRDATA,
        output PREADY,
        output PSLVERR
    );

endinterface

// File: rtl/apb_master_port.sv
// rtl/apb_master_port.sv - single-outstanding APB initiator with wait-state timeout
//
// Purpose: accepts one request at a time on a valid/ready channel, runs it
// as an APB SETUP/ACCESS transfer and returns the result on a valid/ready
// response channel. A hung slave (PREADY held low) is aborted after
// TIMEOUT_CYCLES ACCESS cycles and reported as an error with
// rsp_timeout_o set.
//
// Parameters:
//   APB_ADDR_WIDTH - width of PADDR / req_addr_i
//   TIMEOUT_CYCLES - ACCESS cycles with PREADY low before abort, 0 = never
//   CNT_WIDTH      - wait counter width, 2**CNT_WIDTH > TIMEOUT_CYCLES
//
// Ports:
//   HCLK    - clock
//   HRESET  - asynchronous active-high reset
//   bus     - apb_master_port_if.master: request channel (req_*), response
//             channel (rsp_*) and the APB initiator signals (P*)
//
// Latency: a request accepted in cycle T gives PSEL in T+1, PENABLE in T+2
// and, with no wait states, rsp_valid_o in T+3. Everything except
// req_ready_o comes straight from flops.

module apb_master_port #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 9
) (
    input  logic              HCLK,
    input  logic              HRESET,
    apb_master_port_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam bit                   TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
        CNT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

    state_t                    state;
    logic [CNT_WIDTH-1:0]      wait_cnt;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [31:0]               pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic                      rsp_valid;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_timeout;
    logic                      timeout_hit;

    // wait_cnt counts completed ACCESS cycles with PREADY low, so the
    // TIMEOUT_CYCLES-th such cycle is the one where it equals TIMEOUT_LAST.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST);

    // Gated with HRESET so the requester never sees ready during reset,
    // while still being high in the very first cycle after release.
    assign bus.req_ready_o = (state == IDLE) && !HRESET;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready_o is high throughout IDLE once out of reset
                    if (bus.req_valid_i) begin
                        paddr   <= bus.req_addr_i;
                        pwdata  <= bus.req_wdata_i;
                        pwrite  <= bus.req_write_i;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end

                ACCESS: begin
                    // Completion is tested first so a PREADY arriving on the
                    // threshold cycle finishes the transfer normally.
                    if (bus.PREADY) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_rdata   <= pwrite ? 32'd0 : bus.PRDATA;
                        rsp_err     <= bus.PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_rdata   <= 32'd0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        // Saturates so a disabled timeout never wraps into
                        // a false match.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    // rsp_rdata is left as is; only the flags are cleared.
                    if (bus.rsp_ready_i) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.PADDR         = paddr;
    assign bus.PWDATA        = pwdata;
    assign bus.PWRITE        = pwrite;
    assign bus.PSEL          = psel;
    assign bus.PENABLE       = penable;
    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.rsp_rdata_o   = rsp_rdata;
    assign bus.rsp_err_o     = rsp_err;
    assign bus.rsp_timeout_o = rsp_timeout;

endmodule

// File: tb/tb_apb_master_port.sv
// tb/tb_apb_master_port.sv - scoreboard testbench for apb_master_port

module tb_apb_master_port;

    localparam int AW = 12;
    localparam int TO = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          write;
        int            waits;
        logic [31:0]   prd;
        logic          serr;
        logic [31:0]   rdata;
        logic          err;
        logic          tmo;
        int            lat;
        int            t_acc;
    } txn_t;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;

    txn_t plan_q[$];
    txn_t exp_q[$];

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    apb_master_port_if #(.APB_ADDR_WIDTH(AW)) bus ();

    apb_master_port #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (3)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the response a transfer must produce, from the rules
    // alone. A slave that would need TO or more wait states is cut off after
    // TO ACCESS cycles.
    function automatic txn_t build(input logic [AW-1:0] addr, input logic [31:0] wdata,
                                   input logic write, input int waits,
                                   input logic [31:0] prd, input logic serr);
        txn_t t;
        t.addr  = addr;
        t.wdata = wdata;
        t.write = write;
        t.waits = waits;
        t.prd   = prd;
        t.serr  = serr;
        t.t_acc = 0;
        if (waits >= TO) begin
            t.rdata = 32'd0;
            t.err   = 1'b1;
            t.tmo   = 1'b1;
            t.lat   = 2 + TO;
        end else begin
            t.rdata = write ? 32'd0 : prd;
            t.err   = serr;
            t.tmo   = 1'b0;
            t.lat   = 3 + waits;
        end
        return t;
    endfunction

    // Called just after a negedge; returns just after a negedge.
    task automatic issue(input txn_t t_in);
        txn_t t;
        int   guard;
        t     = t_in;
        guard = 0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = t.addr;
        bus.req_wdata_i = t.wdata;
        bus.req_write_i = t.write;
        while (!bus.req_ready_o && guard < 200) begin
            @(negedge HCLK);
            guard++;
        end
        if (!bus.req_ready_o) begin
            check("req_accept_bound", 64'(bus.req_ready_o), 64'd1);
            bus.req_valid_i = 1'b0;
            @(negedge HCLK);
        end else begin
            t.t_acc = cyc;
            plan_q.push_back(t);
            exp_q.push_back(t);
            @(posedge HCLK);
            #1;
            bus.req_valid_i = 1'b0;
            bus.req_addr_i  = 12'($urandom_range(0, 4095));
            bus.req_wdata_i = $urandom;
            bus.req_write_i = 1'($urandom_range(0, 1));
            @(negedge HCLK);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid_o) && g < 3000) begin
            @(negedge HCLK);
            g++;
        end
        if (g >= 3000) check("drain_bound", 64'(exp_q.size()), 64'd0);
    endtask

    // APB slave: follows the plan of each accepted request, drives noise
    // on its outputs outside ACCESS, and checks the held address phase.
    initial begin : slave
        txn_t s;
        logic act;
        int   acc;
        act = 1'b0;
        acc = 0;
        s   = build('0, '0, 1'b0, 0, '0, 1'b0);
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge HCLK);
            if (HRESET || !(bus.PSEL && bus.PENABLE)) begin
                act         = 1'b0;
                bus.PREADY  = 1'($urandom_range(0, 1));
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom_range(0, 1));
            end else begin
                if (!act) begin
                    if (plan_q.size() == 0) begin
                        check("unexpected_access", 64'(plan_q.size()), 64'd1);
                        s = build('0, '0, 1'b0, 0, '0, 1'b0);
                    end else begin
                        s = plan_q.pop_front();
                    end
                    act = 1'b1;
                    acc = 0;
                end else begin
                    acc++;
                end
                check("paddr",  64'(bus.PADDR),  64'(s.addr));
                check("pwdata", 64'(bus.PWDATA), 64'(s.wdata));
                check("pwrite", 64'(bus.PWRITE), 64'(s.write));
                if (acc == s.waits) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = s.prd;
                    bus.PSLVERR = s.serr;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = $urandom;
                    bus.PSLVERR = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, checks
    // content and latency, then holds rsp_ready low for a random spell
    // while checking that the response stays put.
    initial begin : monitor
        txn_t        cur;
        logic        holding;
        logic        prev_hs;
        int          hold_left;
        logic [33:0] held;
        holding   = 1'b0;
        prev_hs   = 1'b0;
        hold_left = 0;
        held      = '0;
        bus.rsp_ready_i = 1'b0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                holding = 1'b0;
                prev_hs = 1'b0;
                bus.rsp_ready_i = 1'b0;
            end else begin
                if (prev_hs) check("req_ready_after_rsp", 64'(bus.req_ready_o), 64'd1);
                prev_hs = 1'b0;
                if (bus.rsp_valid_o) begin
                    check("psel_in_rsp", 64'(bus.PSEL), 64'd0);
                    check("req_ready_in_rsp", 64'(bus.req_ready_o), 64'd0);
                    if (!holding) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_rsp", 64'(exp_q.size()), 64'd1);
                        end else begin
                            cur = exp_q.pop_front();
                            check("rsp_rdata",   64'(bus.rsp_rdata_o),   64'(cur.rdata));
                            check("rsp_err",     64'(bus.rsp_err_o),     64'(cur.err));
                            check("rsp_timeout", 64'(bus.rsp_timeout_o), 64'(cur.tmo));
                            check("rsp_latency", 64'(cyc - cur.t_acc),   64'(cur.lat));
                        end
                        holding   = 1'b1;
                        held      = {bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o};
                        hold_left = ($urandom_range(0, 3) == 0) ? 5 : int'($urandom_range(0, 2));
                    end else begin
                        check("rsp_stable",
                              64'({bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o}),
                              64'(held));
                    end
                    if (hold_left == 0) begin
                        bus.rsp_ready_i = 1'b1;
                        holding = 1'b0;
                        prev_hs = 1'b1;
                    end else begin
                        bus.rsp_ready_i = 1'b0;
                        hold_left--;
                    end
                end else begin
                    bus.rsp_ready_i = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, %0d tests %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r;
        int w;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_write_i = 1'b0;

        repeat (3) @(negedge HCLK);
        check("rst_psel",      64'(bus.PSEL),          64'd0);
        check("rst_penable",   64'(bus.PENABLE),       64'd0);
        check("rst_addr_bus",  64'({bus.PADDR, bus.PWRITE}), 64'd0);
        check("rst_pwdata",    64'(bus.PWDATA),        64'd0);
        check("rst_rsp",       64'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata_o),   64'd0);
        check("rst_req_ready", 64'(bus.req_ready_o),   64'd0);
        HRESET = 1'b0;
        #1;
        check("req_ready_after_release", 64'(bus.req_ready_o), 64'd1);
        @(negedge HCLK);

        // Directed cases
        issue(build(12'h004, 32'hDEADBEEF, 1'b1, 0, $urandom, 1'b0));
        issue(build(12'h008, $urandom, 1'b0, 2, 32'h0000_00A5, 1'b0));
        issue(build(12'h010, $urandom, 1'b0, 0, 32'h0000_1234, 1'b1));
        issue(build(12'h014, $urandom, 1'b0, 99, $urandom, 1'b0));
        issue(build(12'h018, $urandom, 1'b0, TO - 1, 32'h0BAD_CAFE, 1'b0));
        issue(build(12'h01C, 32'h5555_AAAA, 1'b1, 99, $urandom, 1'b1));

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            w = (r == 9) ? 99 : ((r <= 2) ? 0 : r - 2);
            issue(build(12'($urandom_range(0, 4095)), $urandom, 1'($urandom_range(0, 1)),
                        w, $urandom, 1'($urandom_range(0, 1))));
            repeat ($urandom_range(0, 2)) @(negedge HCLK);
        end
        drain();

        // Reset during a wait state of a read
        issue(build(12'h0C0, 32'h0, 1'b0, 3, 32'h5A5A_5A5A, 1'b0));
        @(negedge HCLK);
        @(negedge HCLK);
        check("mid_access_penable", 64'(bus.PENABLE), 64'd1);
        #2;
        HRESET = 1'b1;
        #1;
        check("async_rst_bus", 64'({bus.PSEL, bus.PENABLE, bus.rsp_valid_o}), 64'd0);
        check("async_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        plan_q.delete();
        exp_q.delete();
        @(negedge HCLK);
        check("rst_paddr_cleared", 64'({bus.PADDR, bus.PWDATA}), 64'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        check("req_ready_after_rerelease", 64'(bus.req_ready_o), 64'd1);
        @(negedge HCLK);
        issue(build(12'h0C4, $urandom, 1'b0, 1, 32'hCAFE_F00D, 1'b0));
        drain();

        repeat (3) @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
